// File: rtl/decode_stage_if.sv
// Fetch-to-execute bus for decode_stage: instruction handshake in, decoded bundle out.
// master = the side that drives the instruction and consumes the bundle; slave = decode_stage.
interface decode_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PC_W  = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_alu_op;
    logic [3:0]       out_alu_ctr;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [4:0]       out_shamt;
    logic [5:0]       out_funct;
    logic [WIDTH-1:0] out_imm;
    logic             out_reg_write;
    logic             out_mem_read;
    logic             out_mem_write;
    logic             out_branch;
    logic [4:0]       out_dst;
    logic             out_illegal;
    logic [PC_W-1:0]  out_pc;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_op, out_alu_ctr, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_dst, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_alu_op, out_alu_ctr, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_dst, out_illegal, out_pc
    );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS-style decode stage with valid/ready on both sides and optional skid entry.
// Define DECODE_MULDIV_EN to decode the R-type MUL/DIV funct codes.
module decode_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned SKID  = 1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
`ifdef DECODE_MULDIV_EN
    localparam logic [FUNCT_W-1:0] F_MUL = 6'b011000;
    localparam logic [FUNCT_W-1:0] F_DIV = 6'b011010;
`endif

    typedef struct packed {
        logic [1:0]         alu_op;
        logic [3:0]         alu_ctr;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   shamt;
        logic [FUNCT_W-1:0] funct;
        logic [WIDTH-1:0]   imm;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [REG_W-1:0]   dst;
        logic               illegal;
        logic [PC_W-1:0]    pc;
    } bundle_t;

    bundle_t dec_c;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_vld_q, main_vld_d;
    logic    skid_vld_q, skid_vld_d;
    logic    rdy_q, rdy_d;
    logic    accept;
    logic    main_free;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;

    assign op    = bus.in_inst[31:26];
    assign funct = bus.in_inst[5:0];

    // Field split and control decode of the incoming word
    always_comb begin
        dec_c           = '0;
        dec_c.rs        = bus.in_inst[25:21];
        dec_c.rt        = bus.in_inst[20:16];
        dec_c.rd        = bus.in_inst[15:11];
        dec_c.shamt     = bus.in_inst[10:6];
        dec_c.funct     = funct;
        dec_c.imm       = WIDTH'($signed(bus.in_inst[15:0]));
        dec_c.pc        = bus.in_pc;
        dec_c.alu_ctr   = 4'b0010;
        case (op)
            OP_RTYPE: begin
                dec_c.alu_op    = 2'b10;
                dec_c.reg_write = 1'b1;
                dec_c.dst       = bus.in_inst[15:11];
                case (funct)
                    F_ADD:   dec_c.alu_ctr = 4'b0010;
                    F_SUB:   dec_c.alu_ctr = 4'b0110;
                    F_AND:   dec_c.alu_ctr = 4'b0000;
                    F_OR:    dec_c.alu_ctr = 4'b0001;
`ifdef DECODE_MULDIV_EN
                    F_MUL:   dec_c.alu_ctr = 4'b0011;
                    F_DIV:   dec_c.alu_ctr = 4'b0100;
`endif
                    default: begin
                        dec_c.alu_ctr   = 4'b0000;
                        dec_c.illegal   = 1'b1;
                        dec_c.reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_c.mem_read  = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.dst       = bus.in_inst[20:16];
            end
            OP_SW: begin
                dec_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_c.alu_op  = 2'b01;
                dec_c.alu_ctr = 4'b0110;
                dec_c.branch  = 1'b1;
            end
            OP_ADDI: begin
                dec_c.reg_write = 1'b1;
                dec_c.dst       = bus.in_inst[20:16];
            end
            default: begin
                dec_c.illegal = 1'b1;
            end
        endcase
    end

    // in_ready is forced low during reset; with a skid entry it comes straight from a flop
    assign bus.in_ready = !rst && ((SKID != 0) ? rdy_q : (!main_vld_q || bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign main_free    = !main_vld_q || bus.out_ready;

    // Occupancy update: skid refills main first; stalled accepts park in skid
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (main_free) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = dec_c;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec_c;
            skid_vld_d = 1'b1;
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign bus.out_valid     = main_vld_q;
    assign bus.out_alu_op    = main_q.alu_op;
    assign bus.out_alu_ctr   = main_q.alu_ctr;
    assign bus.out_rs        = main_q.rs;
    assign bus.out_rt        = main_q.rt;
    assign bus.out_rd        = main_q.rd;
    assign bus.out_shamt     = main_q.shamt;
    assign bus.out_funct     = main_q.funct;
    assign bus.out_imm       = main_q.imm;
    assign bus.out_reg_write = main_q.reg_write;
    assign bus.out_mem_read  = main_q.mem_read;
    assign bus.out_mem_write = main_q.mem_write;
    assign bus.out_branch    = main_q.branch;
    assign bus.out_dst       = main_q.dst;
    assign bus.out_illegal   = main_q.illegal;
    assign bus.out_pc        = main_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps plus random traffic against a
// two-deep FIFO reference model fed by a table-driven decoder.
module tb_decode_stage;
    logic clk;
    logic rst;

    decode_stage_if #(.WIDTH(32), .PC_W(32)) bus ();

    decode_stage #(.WIDTH(32), .PC_W(32), .SKID(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  alu_op;
        logic [3:0]  ctr;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic        rw, mr, mw, br;
        logic [4:0]  dst;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int   passed = 0;
    int   total  = 0;
    exp_t mq[$];
    logic zero_exp = 1'b1;
    logic last_acc = 1'b0;

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   op;
        int   fn;
        op = int'(inst >> 26);
        fn = int'(inst & 32'h3f);
        e.rs    = 5'((inst >> 21) & 32'h1f);
        e.rt    = 5'((inst >> 16) & 32'h1f);
        e.rd    = 5'((inst >> 11) & 32'h1f);
        e.sh    = 5'((inst >> 6) & 32'h1f);
        e.funct = 6'(fn);
        e.imm   = (inst & 32'h8000) != 0 ? (32'hFFFF_0000 | (inst & 32'hFFFF)) : (inst & 32'hFFFF);
        e.pc    = pc;
        e.alu_op = 2'd0; e.ctr = 4'd2; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.dst = 0; e.ill = 0;
        if (op == 0) begin
            e.alu_op = 2'd2; e.rw = 1; e.dst = e.rd;
            if (fn == 32) e.ctr = 4'd2;
            else if (fn == 34) e.ctr = 4'd6;
            else if (fn == 36) e.ctr = 4'd0;
            else if (fn == 37) e.ctr = 4'd1;
`ifdef DECODE_MULDIV_EN
            else if (fn == 24) e.ctr = 4'd3;
            else if (fn == 26) e.ctr = 4'd4;
`endif
            else begin e.ctr = 4'd0; e.ill = 1; e.rw = 0; end
        end else if (op == 35) begin
            e.mr = 1; e.rw = 1; e.dst = e.rt;
        end else if (op == 43) begin
            e.mw = 1;
        end else if (op == 4) begin
            e.alu_op = 2'd1; e.ctr = 4'd6; e.br = 1;
        end else if (op == 8) begin
            e.rw = 1; e.dst = e.rt;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0, 1: w[31:26] = 6'd0;
            2:    w[31:26] = 6'd35;
            3:    w[31:26] = 6'd43;
            4:    w[31:26] = 6'd4;
            5:    w[31:26] = 6'd8;
            default: ;
        endcase
        if (w[31:26] == 6'd0) begin
            case ($urandom_range(0, 6))
                0: w[5:0] = 6'd32;
                1: w[5:0] = 6'd34;
                2: w[5:0] = 6'd36;
                3: w[5:0] = 6'd37;
                4: w[5:0] = 6'd24;
                5: w[5:0] = 6'd26;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_payload(input exp_t e);
        chk("alu_op", bus.out_alu_op, e.alu_op);
        chk("alu_ctr", bus.out_alu_ctr, e.ctr);
        chk("rs", bus.out_rs, e.rs);
        chk("rt", bus.out_rt, e.rt);
        chk("rd", bus.out_rd, e.rd);
        chk("shamt", bus.out_shamt, e.sh);
        chk("funct", bus.out_funct, e.funct);
        chk("imm", bus.out_imm, e.imm);
        chk("reg_write", bus.out_reg_write, e.rw);
        chk("mem_read", bus.out_mem_read, e.mr);
        chk("mem_write", bus.out_mem_write, e.mw);
        chk("branch", bus.out_branch, e.br);
        chk("dst", bus.out_dst, e.dst);
        chk("illegal", bus.out_illegal, e.ill);
        chk("pc", bus.out_pc, e.pc);
    endtask

    task automatic check_state();
        exp_t z;
        z = '{default: '0};
        chk("in_ready", bus.in_ready, rst ? 1'b0 : (mq.size() < 2));
        chk("out_valid", bus.out_valid, mq.size() > 0);
        if (mq.size() > 0) check_payload(mq[0]);
        else if (zero_exp) check_payload(z);
    endtask

    // One clock: drive inputs, check pre-edge state, advance the model across the edge
    task automatic tick(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic r);
        logic acc;
        logic drn;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        check_state();
        acc = !r && v && (mq.size() < 2);
        drn = !r && ordy && (mq.size() > 0);
        @(posedge clk);
        if (r) begin
            mq.delete();
            zero_exp = 1'b1;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(ref_decode(inst, pc));
                zero_exp = 1'b0;
            end
        end
        last_acc = acc;
        #1;
    endtask

    initial begin
        logic        pend;
        logic [31:0] pi;
        logic [31:0] pc_ctr;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick(0, 32'h0, 32'h0, 0, 1);

        // Test-plan decodes, streamed with out_ready high
        tick(1, 32'h0043_0820, 32'h100, 1, 0);
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_alu_op", bus.out_alu_op, 2'b10);
        chk("add_alu_ctr", bus.out_alu_ctr, 4'b0010);
        chk("add_rs", bus.out_rs, 5'd2);
        chk("add_rt", bus.out_rt, 5'd3);
        chk("add_dst", bus.out_dst, 5'd1);
        chk("add_reg_write", bus.out_reg_write, 1'b1);
        tick(1, 32'h8C43_0004, 32'h104, 1, 0);
        chk("lw_alu_op", bus.out_alu_op, 2'b00);
        chk("lw_mem_read", bus.out_mem_read, 1'b1);
        chk("lw_dst", bus.out_dst, 5'd3);
        chk("lw_imm", bus.out_imm, 32'h0000_0004);
        tick(1, 32'h1043_FFFF, 32'h108, 1, 0);
        chk("beq_alu_op", bus.out_alu_op, 2'b01);
        chk("beq_alu_ctr", bus.out_alu_ctr, 4'b0110);
        chk("beq_branch", bus.out_branch, 1'b1);
        chk("beq_imm", bus.out_imm, 32'hFFFF_FFFF);
        tick(1, 32'h0043_0018, 32'h10C, 1, 0);
`ifdef DECODE_MULDIV_EN
        chk("mult_alu_ctr", bus.out_alu_ctr, 4'b0011);
        chk("mult_illegal", bus.out_illegal, 1'b0);
`else
        chk("mult_alu_ctr", bus.out_alu_ctr, 4'b0000);
        chk("mult_illegal", bus.out_illegal, 1'b1);
`endif
        tick(1, 32'hFC00_0000, 32'h110, 1, 0);
        chk("badop_illegal", bus.out_illegal, 1'b1);
        chk("badop_flags", {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_branch}, 4'b0);
        tick(0, 32'h0, 32'h0, 1, 0);

        // Back-pressure: fill main and skid, hold third word, then release
        tick(1, 32'h0022_0820, 32'h200, 0, 0);
        tick(1, 32'h8C22_0008, 32'h204, 0, 0);
        chk("skid_full_in_ready", bus.in_ready, 1'b0);
        tick(1, 32'hAC22_000C, 32'h208, 0, 0);
        tick(1, 32'hAC22_000C, 32'h208, 1, 0);
        tick(1, 32'hAC22_000C, 32'h208, 1, 0);
        tick(0, 32'h0, 32'h0, 1, 0);
        tick(0, 32'h0, 32'h0, 1, 0);

        // Full-rate streaming
        for (int i = 0; i < 8; i++) begin
            tick(1, rand_inst(), 32'h300 + 32'(i) * 4, 1, 0);
            chk("stream_pc", bus.out_pc, 32'h300 + 32'(i) * 4);
        end
        tick(0, 32'h0, 32'h0, 1, 0);

        // Reset with both entries occupied
        tick(1, 32'h0043_0820, 32'h400, 0, 0);
        tick(1, 32'h0043_0822, 32'h404, 0, 0);
        tick(0, 32'h0, 32'h0, 0, 1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_pc", bus.out_pc, 32'h0);
        tick(0, 32'h0, 32'h0, 0, 0);

        // Random traffic; an unaccepted word is held until it is taken
        pend   = 1'b0;
        pi     = '0;
        pc_ctr = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend   = 1'b1;
                pi     = rand_inst();
                pc_ctr = pc_ctr + 32'd4;
            end
            tick(pend, pi, pc_ctr, $urandom_range(0, 3) != 0, 0);
            if (last_acc) pend = 1'b0;
        end
        repeat (3) tick(0, 32'h0, 32'h0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage that replaces the purely combinational opcode/funct decoder. It splits a 32-bit MIPS-style instruction into fields, produces ALUOp/ALUCtr and datapath control flags, and sign-extends the immediate. It sits between the fetch stage and the register-read/ALU stage, with a valid/ready handshake on both sides and an optional two-entry skid buffer, so fetch and execute can stall independently.

## Interface
Parameters:
- WIDTH, 32, datapath width; immediate is sign-extended to WIDTH bits (WIDTH ≥ 16)
- PC_W, 32, width of the PC tag carried alongside the instruction
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage accepts a word this cycle
- in_inst  in  32  instruction {op, rs, rt, rd, shamt, funct} / {op, rs, rt, imm16}
- in_pc  in  PC_W  PC tag
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_alu_op  out  2  00 load/store/addi, 01 beq, 10 R-type
- out_alu_ctr  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 MUL, 0100 DIV
- out_rs, out_rt, out_rd, out_shamt  out  5 each  raw fields
- out_funct  out  6  raw funct field
- out_imm  out  WIDTH  sign-extended inst[15:0]
- out_reg_write, out_mem_read, out_mem_write, out_branch  out  1 each  control flags
- out_dst  out  5  write-back register (rd for R-type, rt for lw/addi, 0 otherwise)
- out_illegal  out  1  unrecognised opcode or funct
- out_pc  out  PC_W  PC tag passed through

## Operation
- Opcode decode:
  - 000000 R-type: alu_op 10, reg_write.
  - 100011 lw: alu_op 00, mem_read, reg_write.
  - 101011 sw: alu_op 00, mem_write.
  - 000100 beq: alu_op 01, branch.
  - 001000 addi: alu_op 00, reg_write.
  - Any other opcode: illegal=1, alu_op 00, all flags 0, dst 0.
- ALUCtr:
  - alu_op 00 gives 0010.
  - alu_op 01 gives 0110.
  - alu_op 10, by funct: 100000 gives 0010; 100010 gives 0110; 100100 gives 0000; 100101 gives 0001.
  - MUL/DIV funct codes are handled per Configuration.
  - An unrecognised R-type funct gives alu_ctr 0000, illegal=1, reg_write=0.
- Decode is fully combinational on in_inst and depends on every field, not only op. The decoded bundle is captured on the handshake in_valid && in_ready.
- SKID=1: the stage holds a main output register plus one skid entry.
  - in_ready = !skid_valid, driven from a register.
  - If a word is accepted while out_valid && !out_ready, it goes into the skid entry.
  - When the main register drains, the skid entry moves into it on the same edge.
- SKID=0: in_ready = !out_valid || out_ready.
- The bundle is stable while out_valid && !out_ready. No bundle is dropped or duplicated.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 bundle/cycle when out_ready is held high.
- Reset values, in the cycle after rst is sampled high:
  - out_valid=0, skid empty, all out_* payload = 0, out_illegal=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
- Reset mid-operation flushes both entries; in-flight bundles are lost.
- Simultaneous accept and drain (main full, out_ready=1, in_valid=1): the new bundle replaces main and the skid stays empty.
- Both entries full with out_ready=1: skid moves to main, in_ready rises the next cycle.
- in_valid while in_ready=0: the word is ignored, and the source must hold it.

## Configuration
- DECODE_MULDIV_EN defined:
  - funct 011000 decodes to alu_ctr 0011 (MUL), reg_write=1, illegal=0.
  - funct 011010 decodes to alu_ctr 0100 (DIV), reg_write=1, illegal=0.
- DECODE_MULDIV_EN undefined: both funct codes are illegal (alu_ctr 0000, illegal=1, reg_write=0).

## Test plan
- Reset, then inst 0x00430820 (add $1,$2,$3) → next cycle out_valid=1, alu_op 10, alu_ctr 0010, rs 2, rt 3, rd 1, dst 1, reg_write 1.
- 0x8C430004 (lw $3,4($2)) → alu_op 00, alu_ctr 0010, mem_read 1, dst 3, imm 0x00000004. Then 0x1043FFFF (beq) → alu_op 01, alu_ctr 0110, branch 1, imm 0xFFFFFFFF.
- 0x00430018 (mult) → with DECODE_MULDIV_EN: alu_ctr 0011, illegal 0. Without it: alu_ctr 0000, illegal 1. Also op 111111 → illegal 1, all flags 0.
- SKID=1, out_ready=0, three back-to-back valid words → first in main, second in skid, in_ready=0, third held. Raise out_ready → bundles emerge in order on consecutive cycles with none lost.
- Streaming with out_ready=1 for 8 words → 8 bundles in order, one per cycle, with out_pc matching in_pc.
- rst asserted with both entries full → next cycle out_valid=0 and payload zero. After release, in_ready=1.
